// File: rtl/fp32_add_arb_if.sv
// Requester and adder-side signal bundle for fp32_add_arb.
// The slave modport is the arbiter's view; the master modport is the surrounding datapath.
interface fp32_add_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_data;
  logic               add_valid;
  logic [31:0]        add_a;
  logic [31:0]        add_b;
  logic [31:0]        add_y;
  logic               add_ready;
  logic               busy;
  logic               err;

  modport slave (
    input  req_valid, req_a, req_b, add_y, add_ready,
    output req_ready, rsp_valid, rsp_data, add_valid, add_a, add_b, busy, err
  );

  modport master (
    output req_valid, req_a, req_b, add_y, add_ready,
    input  req_ready, rsp_valid, rsp_data, add_valid, add_a, add_b, busy, err
  );
endinterface

// File: rtl/fp32_add_arb.sv
// Round-robin arbiter sharing one pipelined fp32 adder between NREQ requesters;
// a tag pipe matching the adder latency routes each result back to its issuer.
module fp32_add_arb #(
  parameter  int NREQ = 4,
  parameter  int LAT  = 11,
  localparam int TAGW = $clog2(NREQ)
) (
  input logic           clk,
  input logic           rstn,
  fp32_add_arb_if.slave bus
);

  typedef struct packed {
    logic            v;
    logic [TAGW-1:0] tag;
  } tag_t;

  logic [TAGW-1:0] rr;
  logic [NREQ-1:0] grant;
  logic [TAGW-1:0] win;
  logic            accept;
  int              idx;

  logic            add_valid_q;
  logic [31:0]     add_a_q;
  logic [31:0]     add_b_q;
  logic [TAGW-1:0] tag0;
  tag_t            pipe [LAT];
  tag_t            tail;

  logic [NREQ-1:0] rsp_valid_q;
  logic [31:0]     rsp_data_q;
  logic            err_q;
  logic            any_v;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    grant  = '0;
    win    = '0;
    accept = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!accept && bus.req_valid[idx]) begin
        accept     = 1'b1;
        grant[idx] = 1'b1;
        win        = TAGW'(idx);
      end
    end
    // Grants are suppressed while reset is held, even with requests pending.
    if (!rstn) begin
      grant  = '0;
      accept = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr          <= '0;
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      tag0        <= '0;
    end else begin
      add_valid_q <= accept;
      if (accept) begin
        rr      <= (int'(win) == NREQ - 1) ? '0 : win + TAGW'(1);
        add_a_q <= bus.req_a[int'(win)*32 +: 32];
        add_b_q <= bus.req_b[int'(win)*32 +: 32];
        tag0    <= win;
      end
    end
  end

  // NOTE: the tag pipe is reset, unlike a data RAM, because a stale valid bit would fire a response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{v: add_valid_q, tag: tag0};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[LAT-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (bus.add_ready && tail.v) begin
        rsp_valid_q <= NREQ'(1) << tail.tag;
        rsp_data_q  <= bus.add_y;
      end
      // A result without a tag, or a tag without a result, means the adder latency is misconfigured.
      if (bus.add_ready != tail.v) err_q <= 1'b1;
    end
  end

  always_comb begin
    any_v = 1'b0;
    for (int i = 0; i < LAT; i++) any_v = any_v | pipe[i].v;
  end

  assign bus.req_ready = grant;
  assign bus.add_valid = add_valid_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.err       = err_q;
  assign bus.busy      = add_valid_q | any_v;

endmodule

// File: tb/tb_fp32_add_arb.sv
// Self-checking bench for fp32_add_arb: table-driven arbitration vectors, hand sequences
// for latency/reset/misalignment, and random traffic against a queue-based reference model.
module tb_fp32_add_arb;
  localparam int NREQ = 4;
  localparam int LAT  = 11;

  logic clk = 1'b0;
  logic rstn;
  logic inject;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   mrr;
  int   rsp_cnt [NREQ];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp32_add_arb_if #(.NREQ(NREQ)) bus ();

  fp32_add_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Stand-in adder: the arbiter does no arithmetic, so any distinct function of the
  // operands exposes misrouting; the one exact fp32 sum used by the single-op case is special-cased.
  function automatic logic [31:0] adder_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h1;
  endfunction

  logic [LAT-1:0] av_sr;
  logic [31:0]    ay_sr [LAT];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      av_sr <= '0;
      for (int i = 0; i < LAT; i++) ay_sr[i] <= '0;
    end else begin
      av_sr    <= {av_sr[LAT-2:0], bus.add_valid};
      ay_sr[0] <= adder_fn(bus.add_a, bus.add_b);
      for (int i = 1; i < LAT; i++) ay_sr[i] <= ay_sr[i-1];
    end
  end

  assign bus.add_ready = av_sr[LAT-1] | inject;
  assign bus.add_y     = ay_sr[LAT-1];

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t expq[$];
  exp_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest outstanding issue.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.rsp_valid != '0) begin
        if (expq.size() == 0) begin
          check("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
        end else begin
          e = expq.pop_front();
          check("rsp_route", 32'(bus.rsp_valid), 32'(1) << e.idx);
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_time", cyc, e.due);
          rsp_cnt[e.idx]++;
        end
      end else if (expq.size() != 0 && expq[0].due <= cyc) begin
        e = expq.pop_front();
        check("rsp_missing", 32'(bus.rsp_valid), 32'(1) << e.idx);
      end
    end
  end

  // One clock cycle: entered and left at posedge+1, inputs held across the next edge.
  task automatic cycle(input logic [NREQ-1:0] mask, input logic [NREQ*32-1:0] a,
                       input logic [NREQ*32-1:0] b, output logic [NREQ-1:0] got);
    int w;
    bus.req_valid = mask;
    bus.req_a     = a;
    bus.req_b     = b;
    #1;
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (w < 0 && mask[(mrr + i) % NREQ]) w = (mrr + i) % NREQ;
    end
    check("req_ready", 32'(bus.req_ready), (w < 0) ? 32'h0 : 32'(1) << w);
    if (w >= 0) begin
      expq.push_back('{idx: w, data: adder_fn(a[w*32 +: 32], b[w*32 +: 32]), due: cyc + LAT + 2});
      mrr = (w + 1) % NREQ;
    end
    got = bus.req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic [NREQ-1:0] g;
    repeat (n) cycle('0, '0, '0, g);
  endtask

  task automatic drain();
    int budget = LAT + 10;
    while (expq.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    check("drain_empty", expq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, "_rsp_data"},  bus.rsp_data, 32'h0);
    check({tag, "_add_valid"}, 32'(bus.add_valid), 32'h0);
    check({tag, "_add_a"},     bus.add_a, 32'h0);
    check({tag, "_add_b"},     bus.add_b, 32'h0);
    check({tag, "_busy"},      32'(bus.busy), 32'h0);
    check({tag, "_err"},       32'(bus.err), 32'h0);
  endtask

  // Asserted at posedge+1 (asynchronously), held for two edges, released at posedge+1.
  task automatic do_reset();
    rstn          = 1'b0;
    inject        = 1'b0;
    bus.req_valid = '1;
    #1;
    check_reset_outputs("rst_in");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    expq.delete();
    mrr           = 0;
    bus.req_valid = '0;
    rstn          = 1'b1;
  endtask

  function automatic logic [NREQ*32-1:0] rnd_ops();
    logic [NREQ*32-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  typedef struct {
    int              prime;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] exp_grant;
  } arb_vec_t;

  arb_vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0]    g;
    logic [NREQ*32-1:0] a, b;
    int                 n0, base;

    // Grant after priming with requester p alone (rr becomes p+1).
    tbl[0] = '{2, 4'b1010, 4'b1000};
    tbl[1] = '{3, 4'b1010, 4'b0010};
    tbl[2] = '{0, 4'b0001, 4'b0001};
    tbl[3] = '{1, 4'b0011, 4'b0001};
    tbl[4] = '{1, 4'b1111, 4'b0100};
    tbl[5] = '{3, 4'b1000, 4'b1000};
    tbl[6] = '{0, 4'b0000, 4'b0000};
    tbl[7] = '{0, 4'b0110, 4'b0010};

    for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;
    rstn   = 1'b0;
    inject = 1'b0;
    mrr    = 0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single op from requester 2: 1.0 + 2.0.
    a = '0; b = '0;
    a[2*32 +: 32] = 32'h3F80_0000;
    b[2*32 +: 32] = 32'h4000_0000;
    n0 = cyc;
    cycle(4'b0100, a, b, g);
    check("single_grant", 32'(g), 32'h4);
    check("single_add_valid", 32'(bus.add_valid), 32'h1);
    check("single_add_a", bus.add_a, 32'h3F80_0000);
    check("single_add_b", bus.add_b, 32'h4000_0000);
    idle(1);
    check("single_add_valid_pulse", 32'(bus.add_valid), 32'h0);
    while (cyc < n0 + LAT + 1) idle(1);
    check("single_busy_high", 32'(bus.busy), 32'h1);
    idle(1);
    check("single_rsp_valid", 32'(bus.rsp_valid), 32'h4);
    check("single_rsp_data", bus.rsp_data, 32'h4040_0000);
    check("single_busy_low", 32'(bus.busy), 32'h0);
    drain();

    // Full contention from a fresh pointer.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle('1, rnd_ops(), rnd_ops(), g);
      check("contention_grant", 32'(g), 32'(1) << (i % NREQ));
    end
    drain();
    check("contention_err", 32'(bus.err), 32'h0);

    // Table-driven arbitration vectors.
    for (int i = 0; i < 8; i++) begin
      cycle(NREQ'(1) << tbl[i].prime, rnd_ops(), rnd_ops(), g);
      cycle(tbl[i].mask, rnd_ops(), rnd_ops(), g);
      check("tbl_grant", 32'(g), 32'(tbl[i].exp_grant));
    end

    // Wrap past 0 and skip 2.
    cycle(4'b0100, rnd_ops(), rnd_ops(), g);
    cycle(4'b1010, rnd_ops(), rnd_ops(), g);
    check("wrap_grant3", 32'(g), 32'h8);
    cycle(4'b1010, rnd_ops(), rnd_ops(), g);
    check("wrap_grant1", 32'(g), 32'h2);
    drain();

    // Requester 0 held for 20 cycles.
    base = rsp_cnt[0];
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0001, rnd_ops(), rnd_ops(), g);
      check("b2b_busy", 32'(bus.busy), 32'h1);
    end
    drain();
    check("b2b_rsp_count", rsp_cnt[0] - base, 20);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cycle(NREQ'($urandom_range(0, (1 << NREQ) - 1)), rnd_ops(), rnd_ops(), g);
    end
    drain();
    check("random_err", 32'(bus.err), 32'h0);

    // Reset with three ops in flight: nothing may come back.
    for (int i = 0; i < 3; i++) cycle(4'b0010, rnd_ops(), rnd_ops(), g);
    do_reset();
    idle(LAT + 5);
    for (int i = 0; i < 2; i++) cycle(4'b0010, rnd_ops(), rnd_ops(), g);
    drain();
    check("midrst_err", 32'(bus.err), 32'h0);

    // Result strobe with an empty tag pipe.
    inject = 1'b1;
    idle(1);
    inject = 1'b0;
    check("misalign_err", 32'(bus.err), 32'h1);
    idle(1);
    check("misalign_no_rsp", 32'(bus.rsp_valid), 32'h0);
    idle(5);
    check("misalign_err_sticky", 32'(bus.err), 32'h1);
    do_reset();
    idle(2);
    check("misalign_err_cleared", 32'(bus.err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
